// File: rtl/e_tuple_delay_line_pkg.sv
// Shared packing offsets and width helpers for the tuple delay line.
// No logic; used at elaboration time only.
// Consumers unpack __output with these so field positions stay in one place.
package e_tuple_delay_line_pkg;

  // Field2 always sits at the bottom of the packed output word.
  localparam int FIELD2_LSB = 0;

  // Occupancy counter width: enough bits to hold 0..depth.
  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Field1 sits directly above field2.
  function automatic int field1_lsb(input int w);
    return w;
  endfunction

  // Valid flag sits above both data lanes.
  function automatic int valid_bit(input int w);
    return 2 * w;
  endfunction

  // Occupancy count occupies the top of the word.
  function automatic int count_lsb(input int w);
    return 2 * w + 1;
  endfunction

  // Full packed output width: {count, valid, field1, field2}.
  function automatic int out_width(input int w, input int cw);
    return cw + 1 + 2 * w;
  endfunction

endpackage

// File: rtl/e_tuple_delay_line_if.sv
// Bundle of tuple inputs, stall/flush controls and the packed output word.
// Purely wires; no latency of its own.
// No ready signal: the producer re-presents tuples offered during a stall.
interface e_tuple_delay_line_if
  import e_tuple_delay_line_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 3,
  parameter int CW    = calc_cw(DEPTH)
);

  logic                          _i_valid;
  logic [W-1:0]                  _i_input1;
  logic [W-1:0]                  _i_input2;
  logic                          _i_stall;
  logic                          _i_flush;
  logic [out_width(W, CW)-1:0]   __output;

  // Producer/consumer side: drives the lanes and controls, observes the word.
  modport master (
    output _i_valid,
    output _i_input1,
    output _i_input2,
    output _i_stall,
    output _i_flush,
    input  __output
  );

  // Delay line side.
  modport slave (
    input  _i_valid,
    input  _i_input1,
    input  _i_input2,
    input  _i_stall,
    input  _i_flush,
    output __output
  );

endinterface

// File: rtl/e_tuple_stage.sv
// One {valid, a, b} pipeline register with load-enable and valid clear.
// Latency 1 cycle when enabled.
// Holds its contents when en is low; clr drops only the valid flag.
module e_tuple_stage #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         d_vld,
  input  logic [W-1:0] d_a,
  input  logic [W-1:0] d_b,
  output logic         q_vld,
  output logic [W-1:0] q_a,
  output logic [W-1:0] q_b
);

  // Valid flag: reset/clear win over load, otherwise load when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_vld <= 1'b0;
    end else if (en) begin
      q_vld <= d_vld;
    end
  end

  // Data lanes carry no reset; their value only matters while q_vld is set.
  always_ff @(posedge clk) begin
    if (en) begin
      q_a <= d_a;
      q_b <= d_b;
    end
  end

endmodule

// File: rtl/e_tuple_delay_line.sv
// Parametrised DEPTH-stage tuple delay line with valid, stall, flush and occupancy count.
// Latency DEPTH-1 edges after the sampling edge, plus one per stall cycle.
// Stall freezes all stages (inputs ignored); no backpressure output is produced.
module e_tuple_delay_line
  import e_tuple_delay_line_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 3,
  parameter int CW    = calc_cw(DEPTH)
) (
  input  logic                _i_clk,
  input  logic                _i_rst,
  e_tuple_delay_line_if.slave bus
);

  // Stage state, index 0 is the input end, DEPTH-1 drives the output.
  logic [DEPTH-1:0] v;
  logic [W-1:0]     a [DEPTH];
  logic [W-1:0]     b [DEPTH];

  // Advance only when nothing of higher priority is active.
  logic stage_en;
  logic stage_clr;
  assign stage_en  = !_i_rst && !bus._i_flush && !bus._i_stall;
  assign stage_clr = bus._i_flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      e_tuple_stage #(.W(W)) u_stage (
        .clk   (_i_clk),
        .rst   (_i_rst),
        .en    (stage_en),
        .clr   (stage_clr),
        .d_vld (bus._i_valid),
        .d_a   (bus._i_input1),
        .d_b   (bus._i_input2),
        .q_vld (v[k]),
        .q_a   (a[k]),
        .q_b   (b[k])
      );
    end else begin : g_body
      e_tuple_stage #(.W(W)) u_stage (
        .clk   (_i_clk),
        .rst   (_i_rst),
        .en    (stage_en),
        .clr   (stage_clr),
        .d_vld (v[k-1]),
        .d_a   (a[k-1]),
        .d_b   (b[k-1]),
        .q_vld (v[k]),
        .q_a   (a[k]),
        .q_b   (b[k])
      );
    end
  end

  // Occupancy tracks valid stages: one in at the head, one out at the tail.
  // count >= v[DEPTH-1] always holds, so the subtraction cannot underflow,
  // and a full line only accepts a new tuple as the tail one leaves.
  logic [CW-1:0] count;
  logic [CW:0]   count_sum;
  logic [CW-1:0] count_nxt;

  // Next occupancy on an advance edge, computed one bit wider then trimmed.
  always_comb begin
    count_sum = {1'b0, count};
    count_sum = count_sum + (CW + 1)'(bus._i_valid) - (CW + 1)'(v[DEPTH-1]);
    count_nxt = count_sum[CW-1:0];
  end

  // Counter register with the same priority order as the stages.
  always_ff @(posedge _i_clk) begin
    if (_i_rst || bus._i_flush) begin
      count <= '0;
    end else if (!bus._i_stall) begin
      count <= count_nxt;
    end
  end

  // Invalid output shows zero data so the word is deterministic.
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  assign out_a = a[DEPTH-1] & {W{v[DEPTH-1]}};
  assign out_b = b[DEPTH-1] & {W{v[DEPTH-1]}};

  assign bus.__output = {count, v[DEPTH-1], out_a, out_b};

endmodule

// File: doc/e_tuple_delay_line.md
# e_tuple_delay_line

Parametrised tuple delay line: two independent W-bit lanes enter together, travel through DEPTH register stages, and leave as one packed word. It generalises the fixed three-stage, 4-bit tuple delay. It adds a per-stage valid bit, a global stall, a synchronous flush and an in-flight occupancy count. It sits between producers and consumers in generated pipelines whose latency must be tuned without rewriting the block.

## Interface
Parameters:
- W, default 4: width of each tuple lane.
- DEPTH, default 3: number of register stages; legal range 1..64.
- CW, default $clog2(DEPTH+1): occupancy counter width (derived).

Ports:
- _i_clk, input, 1: clock; all state updates on the rising edge.
- _i_rst, input, 1: reset; synchronous, active-high.
- _i_valid, input, 1: the tuple on the input lanes is valid this cycle.
- _i_input1, input, W: tuple field 1.
- _i_input2, input, W: tuple field 2.
- _i_stall, input, 1: freeze every stage this cycle.
- _i_flush, input, 1: invalidate every stage this cycle.
- __output, output, CW+1+2W: packed as {count, valid, field1, field2}. field2 occupies bits [W-1:0], field1 bits [2W-1:W], valid bit [2W], and count bits [2W+CW:2W+1].

## Operation
- Stage k (0..DEPTH-1) holds {v_k, a_k, b_k}. Stage 0 is loaded from the inputs; stage DEPTH-1 drives __output.
- Advance edge (no stall, no flush, no reset): stage 0 takes {_i_valid, _i_input1, _i_input2}, stage k takes stage k-1, and the old stage DEPTH-1 content is dropped.
- Bubbles (_i_valid=0) propagate as invalid stages. Data registers of invalid stages still load; their values are don't-care internally.
- Output masking: field1 and field2 on __output are zero whenever v_{DEPTH-1}=0, so invalid output is deterministic.
- Stall (_i_stall=1, no flush/reset): no register changes, and input lanes and _i_valid are ignored that cycle.
- Flush (_i_flush=1): all v_k cleared and count cleared to 0. The data registers need not clear.
- Priority: _i_rst > _i_flush > _i_stall > advance. Flush during stall clears; input presented in a flush cycle is discarded.
- Count: a registered counter equal to the number of set v_k, range 0..DEPTH. On an advance edge, next = count + _i_valid − v_{DEPTH-1}. Stall holds it; flush and reset zero it. The counter must never exceed DEPTH or wrap; the verifier checks count == popcount(v) every cycle.
- DEPTH=1: a single stage, latency 1; count is 0 or 1.

## Timing
- Reset: after any edge with _i_rst=1, all v_k=0 and count=0, so __output = 0 in full. Reset mid-stream drops all in-flight tuples. Reset is asserted for ≥1 cycle; no minimum beyond that.
- Latency: a tuple sampled valid at edge t appears on __output after edge t+DEPTH−1, visible during cycle t+DEPTH−1..t+DEPTH. Each stall cycle in between adds exactly one cycle.
- With DEPTH=3 and stimulus applied at the negedge, the value is visible at the third following negedge, matching the legacy fixed block.
- Throughput: one tuple per non-stalled cycle; no ready/backpressure output. The upstream owner must hold or re-present a tuple offered during a stall.
- __output is purely registered plus an AND mask; there is no combinational path from any input to __output.

## Structure
- Shared package/header: the packing offsets (FIELD2_LSB=0, FIELD1_LSB=W, VALID_BIT=2W, COUNT_LSB=2W+1) and the CW derivation, so consumers unpack consistently.
- Sub-module e_tuple_stage: one {valid, a, b} register with load-enable and clear. The top generates DEPTH instances in a chain and owns the counter and output mask.
- Expected size: about 150–250 lines of RTL.

## Test plan
All scenarios use W=4, DEPTH=3.
- Reset, then a single valid tuple input1=0, input2=1 (in_val=0x01) followed by invalid cycles: __output shows valid=1, data 0x01 at the 3rd negedge. Next cycle valid=0, data 0x00; count goes 1,1,1,0.
- Back-to-back valid 0xA5, 0x3C, 0xFF: these emerge on consecutive cycles in order, with count reaching 3 and staying there while the stream is full.
- Valid 0x12, then _i_stall for 2 cycles with input 0x77 valid: 0x12 emerges at cycle 5 instead of 3, 0x77 never appears, and count stays constant during the stall.
- Fill with 0x11, 0x22, then _i_flush together with _i_stall: the next cycle shows count=0, __output=0, and neither tuple ever emerges.
- Assert _i_rst mid-stream with 3 tuples in flight: __output is all zeros after the edge and stays zero for 3 cycles with no input.
- Random valid/stall/flush run of 1000 cycles against a DEPTH-deep reference queue: every emitted tuple matches, and count equals the queue occupancy at every cycle.
